// File: rtl/inv_shift_rows_serial.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_serial
//
// Byte-serial AES (Inv)ShiftRows permutation unit. A 16-byte AES state arrives
// one byte per in_valid cycle in column-major order (index = row + 4*col). The
// permuted state leaves as a contiguous 16-byte burst. Two 16-byte banks
// ping-pong, so block N+1 is written while block N is being read out.
//
// Parameters
//   INVERSE   1: InvShiftRows (out[r][c] = in[r][(c-r) mod 4])
//             0: ShiftRows    (out[r][c] = in[r][(c+r) mod 4])
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data carries a state byte this cycle
//   in_data    state byte, column-major order
//   out_valid  out_data carries a permuted byte
//   out_data   permuted state byte, column-major order (holds when idle)
//   out_last   high with the 16th byte of each burst
//   busy       read engine is emitting a burst (same as out_valid)
// -----------------------------------------------------------------------------
module inv_shift_rows_serial #(
  parameter bit INVERSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  logic [7:0] mem [2][16];

  logic [3:0] wr_cnt;
  logic       wr_bank;
  logic [3:0] rd_cnt;
  logic       rd_bank;
  logic       run;
  logic       start;

  // Source index for output position j = r + 4c. The column arithmetic is
  // done in 2 bits so the mod-4 wrap comes for free.
  function automatic logic [3:0] src(input logic [3:0] j);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;
    r  = j[1:0];
    c  = j[3:2];
    sc = INVERSE ? (c - r) : (c + r);
    return {sc, r};
  endfunction

  // Writing the 16th byte of a block hands that bank to the read engine.
  assign start = in_valid && (wr_cnt == 4'd15);

  // Bank storage needs no reset; stale contents are never read because the
  // read engine only starts on a freshly completed bank.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wr_bank][wr_cnt] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= 4'd0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      wr_cnt <= wr_cnt + 4'd1;
      if (wr_cnt == 4'd15) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Read engine. A start arriving on the edge that emits byte 15 of the
  // previous burst re-arms the engine on the new bank, so bursts chain with
  // no bubble. The old rd_bank is still used for that edge's output byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt    <= 4'd0;
      rd_bank   <= 1'b0;
      run       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      out_valid <= run;
      out_last  <= run && (rd_cnt == 4'd15);
      if (run) begin
        out_data <= mem[rd_bank][src(rd_cnt)];
        rd_cnt   <= rd_cnt + 4'd1;
        if (rd_cnt == 4'd15) begin
          run <= 1'b0;
        end
      end
      if (start) begin
        run     <= 1'b1;
        rd_bank <= wr_bank;
        rd_cnt  <= 4'd0;
      end
    end
  end

  assign busy = out_valid;

endmodule
